// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: bus width, IR field positions and the
// out-select bit assignments used by the register bank and the out-encoder.
package cpu_pkg;

  localparam int DATA_W  = 32;
  localparam int NREGS   = 16;
  localparam int FIELD_W = 4;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;
  localparam int OSEL_W  = 24;

  // Positions of the register requests within the 24-bit out-select word
  typedef enum logic [4:0] {
    OSEL_R0  = 5'd0,  OSEL_R1  = 5'd1,  OSEL_R2  = 5'd2,  OSEL_R3  = 5'd3,
    OSEL_R4  = 5'd4,  OSEL_R5  = 5'd5,  OSEL_R6  = 5'd6,  OSEL_R7  = 5'd7,
    OSEL_R8  = 5'd8,  OSEL_R9  = 5'd9,  OSEL_R10 = 5'd10, OSEL_R11 = 5'd11,
    OSEL_R12 = 5'd12, OSEL_R13 = 5'd13, OSEL_R14 = 5'd14, OSEL_R15 = 5'd15
  } osel_e;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [FIELD_W-1:0] idx);
    logic [NREGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_bank_sel_if.sv
// Control/data bundle between the control unit, bus multiplexer and the register bank.
interface reg_bank_sel_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0]       ir;
  logic                    gra;
  logic                    grb;
  logic                    grc;
  logic                    rin;
  logic                    rout;
  logic                    ba_out;
  logic [DATA_W-1:0]       bus_data;
  logic [NREGS*DATA_W-1:0] reg_q;
  logic [NREGS-1:0]        rout_onehot;
  logic [NREGS-1:0]        sel_onehot;

  modport master (
    output ir, gra, grb, grc, rin, rout, ba_out, bus_data,
    input  reg_q, rout_onehot, sel_onehot
  );

  modport slave (
    input  ir, gra, grb, grc, rin, rout, ba_out, bus_data,
    output reg_q, rout_onehot, sel_onehot
  );
endinterface

// File: rtl/gp_reg32.sv
// General-purpose register with synchronous active-high clear and load enable.
module gp_reg32
  import cpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_bank_sel.sv
// 16 x 32 register bank with Ra/Rb/Rc select decode, out-request generation
// and R0 zero-gating for base-address arithmetic.
module reg_bank_sel
  import cpu_pkg::*;
(
  input  logic           clock,
  input  logic           clear,
  reg_bank_sel_if.slave  bus
);

  logic [FIELD_W-1:0]      w_ra;
  logic [FIELD_W-1:0]      w_rb;
  logic [FIELD_W-1:0]      w_rc;
  logic [NREGS-1:0]        w_sel;
  logic [NREGS-1:0]        w_ld;
  logic [DATA_W-1:0]       w_q [NREGS];
  logic                    w_r0_gate;

  // Only the three fields are sliced out, so unused IR bits never reach the decode
  assign w_ra = bus.ir[RA_LSB +: FIELD_W];
  assign w_rb = bus.ir[RB_LSB +: FIELD_W];
  assign w_rc = bus.ir[RC_LSB +: FIELD_W];

  always_comb begin
    w_sel = '0;
    if (bus.gra) w_sel = w_sel | reg_onehot(w_ra);
    if (bus.grb) w_sel = w_sel | reg_onehot(w_rb);
    if (bus.grc) w_sel = w_sel | reg_onehot(w_rc);
  end

  assign w_ld             = w_sel & {NREGS{bus.rin}};
  assign bus.sel_onehot   = w_sel;
  assign bus.rout_onehot  = w_sel & {NREGS{bus.rout | bus.ba_out}};
  assign w_r0_gate        = bus.ba_out & w_sel[OSEL_R0];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      gp_reg32 #(.W(DATA_W)) u_reg (
        .clock (clock),
        .clear (clear),
        .i_ld  (w_ld[gi]),
        .i_d   (bus.bus_data),
        .o_q   (w_q[gi])
      );

      if (gi == 0) begin : g_r0
        // Gating only masks the driven word; the stored R0 is untouched
        assign bus.reg_q[gi*DATA_W +: DATA_W] = w_r0_gate ? '0 : w_q[gi];
      end else begin : g_rn
        assign bus.reg_q[gi*DATA_W +: DATA_W] = w_q[gi];
      end
    end
  endgenerate

endmodule

// File: doc/reg_bank_sel.md
Name: reg_bank_sel

Overview:
- 16 x 32-bit general-purpose register bank plus the select-and-encode logic that drives it.
- Sits directly upstream of the bus multiplexer:
  - supplies the busin0..busin15 data words;
  - supplies the 16 R-out request bits that feed the 24-to-5 out-encoder.
- Register targets are decoded from the IR fields Ra/Rb/Rc under the Gra/Grb/Grc controls.
- R0 output is gated by BAout so that base-address arithmetic can read a zero.

Parameters:
- DATA_W, 32, register and bus width
- NREGS, 16, number of general-purpose registers (fixed at 16; IR fields are 4 bits)
- RA_LSB, 23, LSB of the Ra field in the IR (Ra = ir[26:23])
- RB_LSB, 19, LSB of the Rb field (Rb = ir[22:19])
- RC_LSB, 15, LSB of the Rc field (Rc = ir[18:15])

Ports:
- clock  in  1  system clock; rising edge active
- clear  in  1  synchronous, active-high reset
- ir  in  32  current instruction register contents
- gra  in  1  select the Ra field
- grb  in  1  select the Rb field
- grc  in  1  select the Rc field
- rin  in  1  write strobe: load bus_data into the selected register(s)
- rout  in  1  drive strobe: request the selected register(s) onto the bus
- ba_out  in  1  base-address out: like rout, but R0 reads as zero
- bus_data  in  32  current bus value (output of the bus multiplexer)
- reg_q  out  512  flattened register outputs; reg_q[32*i+31:32*i] feeds busin<i>
- rout_onehot  out  16  per-register out-request bits to the out-encoder
- sel_onehot  out  16  decoded selection (diagnostic)

Behaviour:
- Clocking and reset:
  - One clock, `clock`. Reset `clear` is synchronous and active-high.
  - On a rising edge with clear=1, all 16 registers become 0. rin is ignored that cycle.
- Decode (combinational):
  - sel_onehot = (gra ? onehot(Ra) : 0) | (grb ? onehot(Rb) : 0) | (grc ? onehot(Rc) : 0).
  - If several G lines are asserted, the selections are ORed. Equal fields collapse to one bit.
  - No G asserted gives sel_onehot = 0.
- Write:
  - On a rising edge with clear=0 and rin=1, every register i with sel_onehot[i]=1 loads bus_data.
  - Multiple selected registers all load the same value.
  - R0 is writable.
- Write latency and bypass:
  - The new value appears on reg_q at the edge, visible in the next cycle.
  - There is no combinational write-through bypass.
- Out request:
  - rout_onehot = sel_onehot & {16{rout | ba_out}}.
  - With rout=0 and ba_out=0, rout_onehot = 0.
- R0 gating:
  - reg_q slice 0 = (ba_out && sel_onehot[0]) ? 0 : R0.
  - The gating affects only the driven value; stored R0 is unchanged.
  - rout=1 with ba_out=0 drives the true R0.
  - Gating applies whenever ba_out=1 and R0 is selected, including when rout=1 at the same time.
- Other outputs: slices 1..15 of reg_q always show their stored values, regardless of rout.
- Simultaneous events:
  - rin and rout in the same cycle on the same register: bus sees the old value, and the register captures bus_data at the edge.
  - clear has priority over rin.
- Reset mid-operation: clear asserted during any control step zeroes all registers on that edge. Outputs follow combinationally from the zeroed state.
- IR values:
  - Bits outside the three fields are ignored.
  - X on unused IR bits must not propagate.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and the field LSB constants;
  - the 24-bit out-select bit positions (R0..R15 = bits 0..15) used by both this block and the encoder.
- One natural sub-module, gp_reg32: a 32-bit register with synchronous active-high clear and load enable, instantiated 16 times.
- Decode and R0 gating stay in reg_bank_sel.

Test Plan:
- Reset: preload R5=0x1234 via rin, assert clear one edge → all reg_q slices 0, rout_onehot=0.
- Write via Ra:
  - ir Ra=3, gra=1, rin=1, bus_data=0xDEADBEEF, one edge → R3=0xDEADBEEF next cycle, all other registers unchanged.
  - Same cycle with rout=1 → rout_onehot=0x0008.
- Multi-select:
  - ir Ra=2, Rb=7, gra=grb=1, rin=1, bus_data=0x55 → R2=R7=0x55.
  - Then rout=1 → rout_onehot=0x0084.
- BAout gating:
  - R0=0xCAFE; ir Rb=0, grb=1, ba_out=1 → slice 0=0, rout_onehot=0x0001, stored R0 still 0xCAFE.
  - Switch to rout=1, ba_out=0 → slice 0=0xCAFE.
- Read/write collision:
  - R4=0x10; gra with Ra=4, rout=1, rin=1, bus_data=0x20 → slice 4=0x10 before the edge, 0x20 after.
- Clear beats rin: clear=1, rin=1, gra Ra=9, bus_data=0xFF → R9=0 after the edge.
